// File: rtl/axis_preamble_framer.sv
// AXI-Stream framer: prefixes each output frame with a fixed preamble, optionally segments long frames and enforces an inter-frame gap.
// Latency: 1 cycle from input handshake to m_axis_tvalid. Backpressure: s_axis_tready is high only in DATA while the output register is free.
module axis_preamble_framer #(
    parameter int C_DATA_WIDTH     = 16,
    parameter int C_PREAMBLE_WORDS = 2,
    parameter logic [C_PREAMBLE_WORDS*C_DATA_WIDTH-1:0] C_PREAMBLE_PATTERN = 32'hABCD_1234,
    parameter int C_FRAME_LEN      = 10,
    parameter int C_GAP_CYCLES     = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    seg_o,
    output logic [15:0]             frame_cnt_o
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GAP} state_t;

    localparam logic [3:0] PRE_LAST  = 4'(C_PREAMBLE_WORDS - 1);
    localparam logic [9:0] DATA_LAST = 10'(C_FRAME_LEN == 0 ? 0 : C_FRAME_LEN - 1);
    localparam logic [7:0] GAP_LAST  = 8'(C_GAP_CYCLES == 0 ? 0 : C_GAP_CYCLES - 1);
    localparam bit         SEG_EN    = (C_FRAME_LEN != 0);

    state_t                  state_q;
    logic [C_DATA_WIDTH-1:0] tdata_q;
    logic                    tvalid_q;
    logic                    tlast_q;
    logic                    seg_flag_q;
    logic                    seg_q;
    logic [3:0]              pre_idx_q;
    logic [9:0]              data_cnt_q;
    logic [7:0]              gap_cnt_q;
    logic [15:0]             frame_cnt_q;

    logic out_free, m_hs, s_hs, forced_d, tlast_d;

    // Preamble words, most-significant word of the pattern first; unused slots read as zero.
    logic [C_DATA_WIDTH-1:0] pre_words [16];
    for (genvar g = 0; g < 16; g++) begin : g_pre
        if (g < C_PREAMBLE_WORDS) begin : g_used
            assign pre_words[g] = C_PREAMBLE_PATTERN[(C_PREAMBLE_WORDS-1-g)*C_DATA_WIDTH +: C_DATA_WIDTH];
        end else begin : g_unused
            assign pre_words[g] = '0;
        end
    end

    assign out_free      = !tvalid_q || m_axis_tready;
    assign m_hs          = tvalid_q && m_axis_tready;
    assign s_axis_tready = (state_q == DATA) && out_free;
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign forced_d      = SEG_EN && (data_cnt_q == DATA_LAST);
    assign tlast_d       = s_axis_tlast || forced_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            seg_flag_q  <= 1'b0;
            seg_q       <= 1'b0;
            pre_idx_q   <= '0;
            data_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            seg_q <= 1'b0;
            if (m_hs) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                if (tlast_q) begin
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                    seg_q       <= seg_flag_q;
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (s_axis_tvalid && out_free) begin
                        tdata_q    <= pre_words[0];
                        tlast_q    <= 1'b0;
                        tvalid_q   <= 1'b1;
                        seg_flag_q <= 1'b0;
                        data_cnt_q <= '0;
                        if (C_PREAMBLE_WORDS == 1) begin
                            state_q <= DATA;
                        end else begin
                            pre_idx_q <= 4'd1;
                            state_q   <= PREAMBLE;
                        end
                    end
                end
                PREAMBLE: begin
                    // Entering DATA as the last word loads lets payload follow it without a bubble.
                    if (m_hs) begin
                        tdata_q   <= pre_words[pre_idx_q];
                        tlast_q   <= 1'b0;
                        tvalid_q  <= 1'b1;
                        pre_idx_q <= pre_idx_q + 4'd1;
                        if (pre_idx_q == PRE_LAST) begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (s_hs) begin
                        tdata_q    <= s_axis_tdata;
                        tlast_q    <= tlast_d;
                        tvalid_q   <= 1'b1;
                        seg_flag_q <= forced_d && !s_axis_tlast;
                        if (tlast_d) begin
                            data_cnt_q <= '0;
                            gap_cnt_q  <= '0;
                            state_q    <= (C_GAP_CYCLES > 0) ? GAP : IDLE;
                        end else begin
                            data_cnt_q <= data_cnt_q + 10'd1;
                        end
                    end
                end
                GAP: begin
                    // The tlast handshake cycle counts, so exactly C_GAP_CYCLES idle cycles reach the output.
                    if (m_hs || !tvalid_q) begin
                        if (gap_cnt_q == GAP_LAST) begin
                            gap_cnt_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign seg_o         = seg_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule
